// File: rtl/cond_unit.sv
// Condition unit: holds the architectural NZCV flags, evaluates the ARM
// condition field of the execute-stage instruction against them and registers
// the gated PCSrc/RegWrite/MemWrite controls for the next pipeline stage.
// Optional macro COND_STATS_EN adds executed/squashed instruction counters.
module cond_unit #(
  parameter logic [3:0]  FLAG_RESET = 4'b0000,
  parameter int unsigned STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [3:0]            cond,
  input  logic [1:0]            flag_write,
  input  logic                  alu_negative,
  input  logic                  alu_zero,
  input  logic                  alu_carry,
  input  logic                  alu_overflow,
  input  logic                  pc_src_in,
  input  logic                  reg_write_in,
  input  logic                  mem_write_in,
  output logic                  out_valid,
  output logic                  cond_ex,
  output logic                  pc_src_out,
  output logic                  reg_write_out,
  output logic                  mem_write_out,
  output logic [3:0]            flags
`ifdef COND_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_exec,
  output logic [STAT_WIDTH-1:0] stat_squash
`endif
);

  logic [3:0] flags_q, flags_d;
  logic       out_valid_q, out_valid_d;
  logic       cond_ex_q, cond_ex_d;
  logic       pc_src_q, pc_src_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_write_q, mem_write_d;

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_true;
  logic ev, ex;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Condition decode works on the stored flags, never on the live ALU flags.
  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      4'b0000: cond_true = flag_z;
      4'b0001: cond_true = ~flag_z;
      4'b0010: cond_true = flag_c;
      4'b0011: cond_true = ~flag_c;
      4'b0100: cond_true = flag_n;
      4'b0101: cond_true = ~flag_n;
      4'b0110: cond_true = flag_v;
      4'b0111: cond_true = ~flag_v;
      4'b1000: cond_true = flag_c & ~flag_z;
      4'b1001: cond_true = ~flag_c | flag_z;
      4'b1010: cond_true = (flag_n == flag_v);
      4'b1011: cond_true = (flag_n != flag_v);
      4'b1100: cond_true = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_true = flag_z | (flag_n != flag_v);
      4'b1110: cond_true = 1'b1;
      4'b1111: cond_true = 1'b0;
    endcase
  end

  assign ev = in_valid & ~flush;
  assign ex = ev & cond_true;

  // Next state: flush clears the output stage even while stalled; flags only
  // move for an executing, non-stalled instruction.
  always_comb begin
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    cond_ex_d   = cond_ex_q;
    pc_src_d    = pc_src_q;
    reg_write_d = reg_write_q;
    mem_write_d = mem_write_q;
    if (flush) begin
      out_valid_d = 1'b0;
      cond_ex_d   = 1'b0;
      pc_src_d    = 1'b0;
      reg_write_d = 1'b0;
      mem_write_d = 1'b0;
    end else if (!stall) begin
      out_valid_d = ev;
      cond_ex_d   = ex;
      pc_src_d    = pc_src_in & ex;
      reg_write_d = reg_write_in & ex;
      mem_write_d = mem_write_in & ex;
    end
    if (ex && !stall) begin
      if (flag_write[1]) flags_d[3:2] = {alu_negative, alu_zero};
      if (flag_write[0]) flags_d[1:0] = {alu_carry, alu_overflow};
    end
  end

  // Flag register and output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q     <= FLAG_RESET;
      out_valid_q <= 1'b0;
      cond_ex_q   <= 1'b0;
      pc_src_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      cond_ex_q   <= cond_ex_d;
      pc_src_q    <= pc_src_d;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign flags         = flags_q;
  assign out_valid     = out_valid_q;
  assign cond_ex       = cond_ex_q;
  assign pc_src_out    = pc_src_q;
  assign reg_write_out = reg_write_q;
  assign mem_write_out = mem_write_q;

`ifdef COND_STATS_EN
  localparam logic [STAT_WIDTH-1:0] StatOne = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

  logic [STAT_WIDTH-1:0] stat_exec_q, stat_exec_d;
  logic [STAT_WIDTH-1:0] stat_squash_q, stat_squash_d;

  // Counters wrap naturally; flushed instructions have ev=0 and count nowhere.
  always_comb begin
    stat_exec_d   = stat_exec_q;
    stat_squash_d = stat_squash_q;
    if (!stall) begin
      if (ex)               stat_exec_d   = stat_exec_q + StatOne;
      if (ev && !cond_true) stat_squash_d = stat_squash_q + StatOne;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_exec_q   <= '0;
      stat_squash_q <= '0;
    end else begin
      stat_exec_q   <= stat_exec_d;
      stat_squash_q <= stat_squash_d;
    end
  end

  assign stat_exec   = stat_exec_q;
  assign stat_squash = stat_squash_q;
`endif

endmodule
